fetch_redirect_unit: RTL and testbench
======================================

// Module: fetch_redirect_unit
// PURPOSE
//  IF-stage PC sequencer and consumer of the ID-stage branch decision.
//  Holds the fetch PC and advances it by 4 each cycle, or redirects it to the branch target when ID resolves a taken BEQ/BNE.
//  On a redirect it flushes the wrong-path instruction in IF/ID.
//  Also supports stall from the hazard unit and halt/resume from the testbench/CPU top.
// PARAMETERS
//  ADDR_W    32  width of PC and address arithmetic
//  RESET_PC  0   PC value loaded on reset
//  CNT_W     16  width of redirect_count
// PORTS
//  clk            in   1       rising-edge clock
//  rst_n          in   1       asynchronous, active-low reset
//  stall_if       in   1       hazard stall; hold PC and ignore branch this cycle
//  branch_valid   in   1       ID holds a BEQ or BNE (BEQ_ID|BNE_ID)
//  branch_taken   in   1       equality-check result for the ID branch
//  branch_offset  in   32      sign-extended word offset from the ID immediate
//  id_pc          in   ADDR_W  PC of the instruction currently in ID
//  halt_req       in   1       request to stop fetching
//  resume         in   1       restart fetching from the held PC
//  pc_out         out  ADDR_W  current fetch address
//  pc_valid       out  1       pc_out is a live fetch (0 when halted)
//  flush_ifid     out  1       zero the IF/ID register at this edge
//  redirect_count out  CNT_W   number of taken redirects, saturating
//  state_out      out  1       0=RUN, 1=HALTED
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - pc_out=RESET_PC, state=RUN, redirect_count=0.
//   - pc_valid=1 once reset is released.
//   - flush_ifid is forced 0 while rst_n=0.
//  take = branch_valid & branch_taken & ~stall_if & (state==RUN).
//  target = id_pc + 4 + (branch_offset<<2), truncated to ADDR_W (wraps mod 2^ADDR_W).
//  RUN, per rising edge, in priority order:
//   1. take:      pc<=target; redirect_count+=1, saturating at all-ones.
//   2. stall_if:  pc held; branch_valid/branch_taken ignored (ID re-presents the branch).
//   3. otherwise: pc<=pc+4, wrapping from 0xFFFFFFFC to 0.
//  flush_ifid: combinational, =take; the same-edge IF/ID capture is squashed. One cycle per redirect, no latency.
//  halt_req in RUN:
//   - Next state HALTED.
//   - The PC update of rule 1/2/3 still applies on that edge, so take+halt_req leaves pc=target.
//  HALTED:
//   - pc held, pc_valid=0, flush_ifid=0; branch inputs and stall_if are ignored.
//   - resume=1 -> RUN next edge, pc unchanged at that edge; pc_valid=1 after the edge.
//   - halt_req and resume both high in HALTED: stay HALTED (halt wins).
//   - resume in RUN: no effect.
//  Reset mid-operation: immediate return to reset values, including from HALTED.
// CONFIGURATION
//  BRANCH_DELAY_SLOT_EN:
//   - Defined: the IF instruction is a delay slot. A taken branch redirects the pc as above, but flush_ifid is tied 0.
//   - Undefined (default): flush_ifid=take as specified.
// TESTING
//  1. Reset: rst_n=0 then 1, no branches for 3 edges -> pc_out 0,4,8,12; pc_valid=1; flush_ifid=0; redirect_count=0.
//  2. Taken branch: id_pc=0x10, offset=3, valid=taken=1 for one cycle -> flush_ifid=1 that cycle; next pc=0x20; redirect_count=1.
//     Repeat with offset=-5 (0xFFFFFFFB) -> pc=0x0.
//  3. Not-taken, then stalled branch:
//     - valid=1, taken=0 at pc=0x40 -> pc=0x44, no flush.
//     - stall_if=1 with valid=taken=1 -> pc held at 0x44, flush_ifid=0, count unchanged.
//  4. Halt/resume:
//     - halt_req with take (target 0x100) -> pc=0x100, state_out=1, pc_valid=0.
//     - 5 idle edges hold 0x100; halt_req+resume stays halted.
//     - resume -> RUN, next pc 0x104.
//  5. Boundaries:
//     - pc=0xFFFFFFFC -> next pc=0.
//     - redirect_count preset near max: 65536 redirects -> stays 0xFFFF.
//     - rst_n pulsed low while HALTED -> pc=RESET_PC, RUN.
//  6. With BRANCH_DELAY_SLOT_EN: repeat test 2 -> pc=0x20, redirect_count=1, flush_ifid stays 0.

Source files
------------

// File: rtl/fetch_redirect_unit.sv
// IF-stage PC sequencer: +4 fetch, redirect on a taken ID branch, stall hold, halt/resume.
// Optional macro BRANCH_DELAY_SLOT_EN: the IF instruction becomes a delay slot, so no IF/ID flush.
module fetch_redirect_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_if,
  input  logic              branch_valid,
  input  logic              branch_taken,
  input  logic [31:0]       branch_offset,
  input  logic [ADDR_W-1:0] id_pc,
  input  logic              halt_req,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc_out,
  output logic              pc_valid,
  output logic              flush_ifid,
  output logic [CNT_W-1:0]  redirect_count,
  output logic              state_out
);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] HALTED = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  cnt;
  logic              take;
  logic [ADDR_W-1:0] byte_off;
  logic [ADDR_W-1:0] target;

  // A stalled ID re-presents its branch next cycle, so it must not redirect now.
  assign take     = branch_valid & branch_taken & ~stall_if & (state == RUN);
  assign byte_off = ADDR_W'($signed({branch_offset, 2'b00}));
  assign target   = id_pc + ADDR_W'(4) + byte_off;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      pc    <= RESET_PC;
      cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (take) begin
            pc <= target;
            if (!(&cnt)) cnt <= cnt + CNT_W'(1);
          end else if (!stall_if) begin
            pc <= pc + ADDR_W'(4);
          end
          if (halt_req) state <= HALTED;
        end
        default: begin
          // Halt wins over a simultaneous resume.
          if (resume && !halt_req) state <= RUN;
        end
      endcase
    end
  end

`ifdef BRANCH_DELAY_SLOT_EN
  assign flush_ifid = 1'b0;
`else
  assign flush_ifid = take & rst_n;
`endif

  assign pc_out         = pc;
  assign pc_valid       = (state == RUN);
  assign redirect_count = cnt;
  assign state_out      = state;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit with a one-deep expected-result queue.
module tb_fetch_redirect_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_if, branch_valid, branch_taken, halt_req, resume;
  logic [31:0] branch_offset, id_pc;
  logic [31:0] pc_out;
  logic        pc_valid, flush_ifid, state_out;
  logic [15:0] redirect_count;

  int n_asrt = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] pc;
    logic        st;
    logic [15:0] cnt;
    logic        vld;
  } exp_t;
  exp_t q[$];

  // Reference state
  logic [31:0] m_pc;
  logic        m_st;
  logic [15:0] m_cnt;

  fetch_redirect_unit #(.ADDR_W(32), .RESET_PC(32'h0), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .stall_if(stall_if), .branch_valid(branch_valid),
    .branch_taken(branch_taken), .branch_offset(branch_offset), .id_pc(id_pc),
    .halt_req(halt_req), .resume(resume), .pc_out(pc_out), .pc_valid(pc_valid),
    .flush_ifid(flush_ifid), .redirect_count(redirect_count), .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs, check flush before the edge, queue and check post-edge state.
  task automatic step(input logic st, input logic bv, input logic bt, input logic [31:0] off,
                      input logic [31:0] ipc, input logic hr, input logic rs);
    logic        tk;
    logic [31:0] tgt;
    exp_t        e, g;
    stall_if = st; branch_valid = bv; branch_taken = bt; branch_offset = off;
    id_pc = ipc; halt_req = hr; resume = rs;
    #1;
    tk  = bv && bt && !st && (m_st == 1'b0);
    tgt = ipc + 32'd4 + (off << 2);
`ifdef BRANCH_DELAY_SLOT_EN
    chk("flush", {31'b0, flush_ifid}, 32'd0);
`else
    chk("flush", {31'b0, flush_ifid}, {31'b0, tk});
`endif
    if (m_st == 1'b0) begin
      if (tk) begin
        m_pc = tgt;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end else if (!st) begin
        m_pc = m_pc + 32'd4;
      end
      if (hr) m_st = 1'b1;
    end else if (rs && !hr) begin
      m_st = 1'b0;
    end
    e.pc = m_pc; e.st = m_st; e.cnt = m_cnt; e.vld = !m_st;
    q.push_back(e);
    @(posedge clk);
    #1;
    g = q.pop_front();
    chk("pc", pc_out, g.pc);
    chk("state", {31'b0, state_out}, {31'b0, g.st});
    chk("count", {16'b0, redirect_count}, {16'b0, g.cnt});
    chk("pc_valid", {31'b0, pc_valid}, {31'b0, g.vld});
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    stall_if = 1'b0; branch_valid = 1'b1; branch_taken = 1'b1;
    branch_offset = 32'd3; id_pc = 32'h10; halt_req = 1'b0; resume = 1'b0;
    m_pc = 32'h0; m_st = 1'b0; m_cnt = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_state", {31'b0, state_out}, 32'd0);
    chk("rst_count", {16'b0, redirect_count}, 32'd0);
    chk("rst_flush", {31'b0, flush_ifid}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_valid", {31'b0, pc_valid}, 32'd1);

    // 1: free-running fetch
    repeat (3) idle();
    chk("t1_pc12", pc_out, 32'd12);

    // 2: taken branches forward and backward
    step(1'b0, 1'b1, 1'b1, 32'd3, 32'h10, 1'b0, 1'b0);
    chk("t2_pc20", pc_out, 32'h20);
    chk("t2_cnt1", {16'b0, redirect_count}, 32'd1);
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFB, 32'h10, 1'b0, 1'b0);
    chk("t2_pc0", pc_out, 32'h0);

    // 3: not-taken then stalled branch
    repeat (16) idle();
    chk("t3_pc40", pc_out, 32'h40);
    step(1'b0, 1'b1, 1'b0, 32'd3, 32'h40, 1'b0, 1'b0);
    chk("t3_pc44", pc_out, 32'h44);
    step(1'b1, 1'b1, 1'b1, 32'd3, 32'h40, 1'b0, 1'b0);
    chk("t3_hold", pc_out, 32'h44);
    chk("t3_cnt", {16'b0, redirect_count}, 32'd2);

    // 4: halt together with a taken branch, then resume
    step(1'b0, 1'b1, 1'b1, 32'd3, 32'hF0, 1'b1, 1'b0);
    chk("t4_pc100", pc_out, 32'h100);
    chk("t4_halted", {31'b0, state_out}, 32'd1);
    for (int i = 0; i < 5; i++) step(i[0], 1'b1, 1'b1, 32'd7, 32'h200, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
    chk("t4_halt_wins", {31'b0, state_out}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("t4_resumed_pc", pc_out, 32'h100);
    idle();
    chk("t4_pc104", pc_out, 32'h104);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("t4_resume_run", pc_out, 32'h108);

    // 5: PC wrap, counter saturation, reset while halted
    step(1'b0, 1'b1, 1'b1, 32'd0, 32'hFFFF_FFF8, 1'b0, 1'b0);
    chk("t5_top", pc_out, 32'hFFFF_FFFC);
    idle();
    chk("t5_wrap", pc_out, 32'h0);
    for (int i = 0; i < 65536; i++) step(1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("t5_sat", {16'b0, redirect_count}, 32'h0000_FFFF);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("t5_halted", {31'b0, state_out}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_pc", pc_out, 32'h0);
    chk("t5_rst_state", {31'b0, state_out}, 32'd0);
    chk("t5_rst_count", {16'b0, redirect_count}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_pc = 32'h0; m_st = 1'b0; m_cnt = 16'h0;
    idle();
    chk("t5_after_rst", pc_out, 32'h4);

    // 6: repeat of the taken branch (flush expectation follows the build option)
    step(1'b0, 1'b1, 1'b1, 32'd3, 32'h10, 1'b0, 1'b0);
    chk("t6_pc20", pc_out, 32'h20);
    chk("t6_cnt1", {16'b0, redirect_count}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
